reward_effect_manager: RTL
==========================

Name: reward_effect_manager

Overview:
- Parametrised successor to the snake game's reward control: manages NUM_TYPES independent timed power-up effects (protection, slow-down, grade multiplier, ...), each with its own countdown.
- Detects the head collecting the on-screen reward, acknowledges the reward generator, and exposes per-type active flags plus remaining-time counts for the information display.
- Sits between the random reward generator and the speed/score/collision logic. Only runs while game_status is PLAYING (2'b10).

Parameters:
- NUM_TYPES, 3, number of effect channels; reward_type value k (1..NUM_TYPES) selects channel k-1; 0 means no reward.
- TYPE_W, 2, width of reward_type; must satisfy 2^TYPE_W > NUM_TYPES.
- POS_W, 6, grid coordinate width.
- CNT_W, 10, width of each remaining-time counter.
- TICK_DIV, 20000000, clk cycles per effect tick (5 Hz at 100 MHz).
- DURATION, 30, ticks an effect stays active after collection.
- RECOVER_MASK, 3'b010, channels that enter a RECOVER window after expiry.
- RECOVER_TICKS, 10, length of the RECOVER window in ticks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_status  in  2  2'b10 = PLAYING; any other value = idle/clear
- head_x, head_y  in  POS_W each  snake head grid position
- reward_valid  in  1  a reward is displayed (generator's set_require)
- reward_x, reward_y  in  POS_W each  reward grid position
- reward_type  in  TYPE_W  type of the displayed reward
- force_sw  in  NUM_TYPES  debug switches; a high bit forces that channel active
- collect_ack  out  1  one-cycle pulse to the generator on a genuine collection
- effect_active  out  NUM_TYPES  channel k is in ACTIVE
- effect_recover  out  NUM_TYPES  channel k is in RECOVER (speed-restore request)
- effect_remain  out  NUM_TYPES*CNT_W  ticks left for channel k, packed at [k*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, prescaler 0, every channel IDLE. Any non-PLAYING game_status gives the same clear synchronously on the next clk edge.
- Prescaler: counts 0..TICK_DIV-1. tick asserts for one cycle when it wraps. Runs only in PLAYING.
- Collection: hit = reward_valid && head_x==reward_x && head_y==reward_y && reward_type in 1..NUM_TYPES.
  - collect_ack is registered, high exactly one cycle after each rising edge of hit.
  - It does not re-fire while hit stays high.
  - An out-of-range reward_type gives no hit and no ack.
- Per-channel FSM, all channels independent; no shared counter:
  - IDLE -> ACTIVE on load (hit for this channel, or force_sw bit high). remain <= DURATION.
  - ACTIVE: on tick, remain decrements. At remain==1, the tick exits to RECOVER if the channel's RECOVER_MASK bit is set, with remain <= RECOVER_TICKS; otherwise it exits to IDLE with remain <= 0.
  - ACTIVE + load: remain reloads to DURATION; state stays ACTIVE.
  - RECOVER: on tick, remain decrements; at remain==1 the tick returns to IDLE. A load returns the channel to ACTIVE with remain DURATION.
- Simultaneous events: a load and a tick in the same cycle give load priority. A force and a hit on different channels both load. A force_sw bit held high keeps reloading, so the channel stays ACTIVE.
- Force does not pulse collect_ack.
- Latency: effect_active rises one cycle after hit or force.

Optional Feature:
- REWARD_STACK_EN defined: a load while ACTIVE adds DURATION to remain, saturating at 2^CNT_W-1, instead of reloading.
- Undefined: reload to DURATION as above.

Test Plan:
- TICK_DIV=4, DURATION=3: head==reward at (5,7), type=1, valid=1 -> collect_ack one cycle, effect_active=3'b001, remain0 3,2,1, then IDLE after 12 clk; active for exactly 3 ticks.
- Type 2 collected with RECOVER_MASK=3'b010, RECOVER_TICKS=2 -> ACTIVE for 3 ticks, then effect_recover[1]=1 for 2 ticks, then all 0.
- Type 1 active with remain0=1, then type 3 hit on the same cycle as a tick -> channel 0 goes IDLE, channel 2 loads to 3; channels do not disturb each other.
- Re-hit type 1 at remain0=1 -> remain0=3 (reload); with REWARD_STACK_EN -> remain0=4.
- force_sw=3'b100 held 2 cycles -> effect_active[2]=1, collect_ack stays 0, remain2=3 after release.
- Mid-ACTIVE, game_status->2'b00 clears all outputs next edge; separately, rst_n low mid-tick clears immediately, with no clk edge needed.

Source files
------------

// File: rtl/reward_effect_manager.sv
// Timed power-up manager: NUM_TYPES independent effect channels, each an IDLE/ACTIVE/RECOVER countdown.
// Optional REWARD_STACK_EN: a load while ACTIVE adds DURATION (saturating) instead of reloading.
module reward_effect_manager #(
  parameter int                   NUM_TYPES     = 3,
  parameter int                   TYPE_W        = 2,
  parameter int                   POS_W         = 6,
  parameter int                   CNT_W         = 10,
  parameter int                   TICK_DIV      = 20000000,
  parameter int                   DURATION      = 30,
  parameter logic [NUM_TYPES-1:0] RECOVER_MASK  = 3'b010,
  parameter int                   RECOVER_TICKS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 game_status,
  input  logic [POS_W-1:0]           head_x,
  input  logic [POS_W-1:0]           head_y,
  input  logic                       reward_valid,
  input  logic [POS_W-1:0]           reward_x,
  input  logic [POS_W-1:0]           reward_y,
  input  logic [TYPE_W-1:0]          reward_type,
  input  logic [NUM_TYPES-1:0]       force_sw,
  output logic                       collect_ack,
  output logic [NUM_TYPES-1:0]       effect_active,
  output logic [NUM_TYPES-1:0]       effect_recover,
  output logic [NUM_TYPES*CNT_W-1:0] effect_remain
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_MAX = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DUR_C  = CNT_W'(DURATION);
  localparam logic [CNT_W-1:0] REC_C  = CNT_W'(RECOVER_TICKS);

  logic            playing;
  logic [PS_W-1:0] presc;
  logic            tick;
  logic            hit;
  logic            hit_prev;
  logic            hit_rise;

  assign playing  = (game_status == 2'b10);
  assign tick     = playing && (presc == PS_MAX);
  assign hit      = reward_valid && (head_x == reward_x) && (head_y == reward_y) &&
                    (reward_type != '0) && (reward_type <= TYPE_W'(NUM_TYPES));
  assign hit_rise = hit && !hit_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!playing) begin
      presc <= '0;
    end else if (presc == PS_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // A collection is its rising edge: one ack, and one load, per arrival of the head on the reward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_prev    <= 1'b0;
      collect_ack <= 1'b0;
    end else if (!playing) begin
      hit_prev    <= 1'b0;
      collect_ack <= 1'b0;
    end else begin
      hit_prev    <= hit;
      collect_ack <= hit_rise;
    end
  end

  for (genvar k = 0; k < NUM_TYPES; k++) begin : g_chan
    state_t           state_q;
    logic [CNT_W-1:0] remain_q;
    logic             active_q;
    logic             recover_q;
    logic             load;

    assign load = force_sw[k] || (hit_rise && (reward_type == TYPE_W'(k + 1)));

`ifdef REWARD_STACK_EN
    logic [CNT_W:0] stacked;
    assign stacked = {1'b0, remain_q} + {1'b0, DUR_C};
`endif

    // Load beats tick; the countdown exits on the tick that finds remain at 1.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= S_IDLE;
        remain_q  <= '0;
        active_q  <= 1'b0;
        recover_q <= 1'b0;
      end else if (!playing) begin
        state_q   <= S_IDLE;
        remain_q  <= '0;
        active_q  <= 1'b0;
        recover_q <= 1'b0;
      end else if (load) begin
        state_q   <= S_ACTIVE;
        active_q  <= 1'b1;
        recover_q <= 1'b0;
`ifdef REWARD_STACK_EN
        if (state_q == S_ACTIVE) begin
          remain_q <= stacked[CNT_W] ? '1 : stacked[CNT_W-1:0];
        end else begin
          remain_q <= DUR_C;
        end
`else
        remain_q  <= DUR_C;
`endif
      end else if (tick) begin
        case (state_q)
          S_ACTIVE: begin
            if (remain_q <= CNT_W'(1)) begin
              if (RECOVER_MASK[k]) begin
                state_q   <= S_RECOVER;
                remain_q  <= REC_C;
                active_q  <= 1'b0;
                recover_q <= 1'b1;
              end else begin
                state_q   <= S_IDLE;
                remain_q  <= '0;
                active_q  <= 1'b0;
                recover_q <= 1'b0;
              end
            end else begin
              remain_q <= remain_q - 1'b1;
            end
          end
          S_RECOVER: begin
            if (remain_q <= CNT_W'(1)) begin
              state_q   <= S_IDLE;
              remain_q  <= '0;
              active_q  <= 1'b0;
              recover_q <= 1'b0;
            end else begin
              remain_q <= remain_q - 1'b1;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            remain_q  <= '0;
            active_q  <= 1'b0;
            recover_q <= 1'b0;
          end
        endcase
      end
    end

    assign effect_active[k]                = active_q;
    assign effect_recover[k]               = recover_q;
    assign effect_remain[k*CNT_W +: CNT_W] = remain_q;
  end

endmodule
